// File: rtl/sram_march_sequencer_if.sv
// Engine-side bus of the march sequencer: start pulses, busy flags, address,
// write data and read-back value shared with the SRAM write/read cycle engines.
interface sram_march_sequencer_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 8
);
   logic              wr_start_out;
   logic              wr_busy_in;
   logic              rd_start_out;
   logic              rd_busy_in;
   logic [ADDR_W-1:0] a_out;
   logic [DATA_W-1:0] d_out;
   logic [DATA_W-1:0] q_in;

   modport master (
      output wr_start_out, rd_start_out, a_out, d_out,
      input  wr_busy_in, rd_busy_in, q_in
   );
   modport slave (
      input  wr_start_out, rd_start_out, a_out, d_out,
      output wr_busy_in, rd_busy_in, q_in
   );
endinterface

// File: rtl/sram_march_sequencer.sv
// 4-phase march test sequencer (write P, read P, write ~P, read ~P) driving the
// SRAM cycle engines. Define SRAM_SEQ_ADDR_DATA_EN for the address-in-data pattern.
module sram_march_sequencer #(
   parameter int ADDR_W         = 9,
   parameter int DATA_W         = 8,
   parameter int ERR_W          = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk_in,
   input  logic                  reset_in,
   input  logic                  start_in,
   input  logic                  abort_in,
   input  logic [DATA_W-1:0]     pattern_in,
   input  logic [ADDR_W-1:0]     addr_last_in,
   sram_march_sequencer_if.master eng,
   output logic                  busy_out,
   output logic                  done_out,
   output logic [1:0]            phase_out,
   output logic [ERR_W-1:0]      err_count_out,
   output logic [ADDR_W-1:0]     first_err_addr_out,
   output logic [DATA_W-1:0]     first_err_data_out,
   output logic                  timeout_out,
   output logic                  aborted_out
);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, CHECK, NEXT, FINISH} state_t;
   state_t state, nstate;

   logic [DATA_W-1:0] pat_q;
   logic [ADDR_W-1:0] last_q, addr_q;
   logic [1:0]        phase_q;
   logic [TMO_W-1:0]  tmo_cnt;
   logic [DATA_W-1:0] base_d, exp_d;
   logic              sel_busy, tmo_hit, last_addr, in_run;

`ifdef SRAM_SEQ_ADDR_DATA_EN
   assign base_d = pat_q ^ addr_q[DATA_W-1:0];
`else
   assign base_d = pat_q;
`endif
   assign exp_d     = phase_q[1] ? ~base_d : base_d;
   assign sel_busy  = phase_q[0] ? eng.rd_busy_in : eng.wr_busy_in;
   assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
   assign last_addr = (addr_q == last_q);

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) state <= IDLE;
      else           state <= nstate;
   end

   always_comb begin
      nstate           = state;
      in_run           = (state != IDLE) && (state != FINISH);
      eng.wr_start_out = (state == ISSUE) && !phase_q[0];
      eng.rd_start_out = (state == ISSUE) &&  phase_q[0];
      done_out         = (state == FINISH);
      busy_out         = in_run;
      // Outside a run both buses park at all ones.
      eng.a_out        = in_run ? addr_q : '1;
      eng.d_out        = in_run ? exp_d  : '1;
      unique case (state)
         IDLE:    if (start_in) nstate = ISSUE;
         ISSUE:   nstate = WAIT_HI;
         WAIT_HI: if (sel_busy) nstate = WAIT_LO;
                  else if (tmo_hit) nstate = FINISH;
         WAIT_LO: if (!sel_busy) nstate = phase_q[0] ? CHECK : NEXT;
         CHECK:   nstate = NEXT;
         NEXT:    if (abort_in || (last_addr && phase_q == 2'd3)) nstate = FINISH;
                  else nstate = ISSUE;
         FINISH:  nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         pat_q              <= '0;
         last_q             <= '0;
         addr_q             <= '0;
         phase_q            <= '0;
         tmo_cnt            <= '0;
         err_count_out      <= '0;
         first_err_addr_out <= '1;
         first_err_data_out <= '1;
         timeout_out        <= 1'b0;
         aborted_out        <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (start_in) begin
               pat_q              <= pattern_in;
               last_q             <= addr_last_in;
               addr_q             <= '0;
               phase_q            <= '0;
               err_count_out      <= '0;
               // First-failure capture returns to its "no failure" value.
               first_err_addr_out <= '1;
               first_err_data_out <= '1;
               timeout_out        <= 1'b0;
               aborted_out        <= 1'b0;
            end
            ISSUE: tmo_cnt <= '0;
            WAIT_HI: if (!sel_busy) begin
               if (tmo_hit) timeout_out <= 1'b1;
               else         tmo_cnt     <= tmo_cnt + 1'b1;
            end
            CHECK: if (eng.q_in != exp_d) begin
               if (err_count_out != '1) err_count_out <= err_count_out + 1'b1;
               if (err_count_out == '0) begin
                  first_err_addr_out <= addr_q;
                  first_err_data_out <= eng.q_in;
               end
            end
            NEXT: begin
               if (abort_in) aborted_out <= 1'b1;
               else if (last_addr) begin
                  addr_q <= '0;
                  if (phase_q != 2'd3) phase_q <= phase_q + 2'd1;
               end else addr_q <= addr_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign phase_out = phase_q;
endmodule
